// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared ALU function codes and divide sequencer state encodings
package div_seq_pkg;

    localparam int DIV_W_DEF = 16;

    localparam logic [4:0] ADD = 5'h00;
    localparam logic [4:0] SUB = 5'h01;
    localparam logic [4:0] SLL = 5'h05;
    localparam logic [4:0] SRL = 5'h06;
    localparam logic [4:0] MUL = 5'h07;
    localparam logic [4:0] DIV = 5'h08;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// rtl/div_seq_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int DIV_W = 16
) (
    input  logic [DIV_W-1:0] rem_i,
    input  logic [DIV_W-1:0] quot_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic [DIV_W-1:0] rem_o,
    output logic [DIV_W-1:0] quot_o
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] trial;

    assign shifted = {rem_i, quot_i[DIV_W-1]};
    assign trial   = shifted - {1'b0, divisor_i};

    // A non-negative trial is always below the divisor, so its top bit is free to act as the sign.
    always_comb begin
        if (!trial[DIV_W]) begin
            rem_o  = trial[DIV_W-1:0];
            quot_o = {quot_i[DIV_W-2:0], 1'b1};
        end else begin
            rem_o  = shifted[DIV_W-1:0];
            quot_o = {quot_i[DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle unsigned restoring divide sequencer for the EX stage
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       func,
    input  logic [DIV_W-1:0] src1,
    input  logic [DIV_W-1:0] src0,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [DIV_W-1:0] quot,
    output logic [DIV_W-1:0] rem,
    output logic             dbz
);

    localparam int CNT_W = (DIV_W > 2) ? $clog2(DIV_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] quot_q, quot_d;
    logic             dbz_q, dbz_d;
    logic [DIV_W-1:0] step_rem, step_quot;
    logic             launch;

    assign launch = start & (func == DIV) & ~flush;

    div_step #(.DIV_W(DIV_W)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (launch) state_d = (src0 == '0) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (count_q == LAST_CNT) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    always_comb begin
        stall = ((state_q == DIV_IDLE) & launch) | (state_q == DIV_RUN);
        done  = (state_q == DIV_DONE);
    end

    // Operands are captured only at launch; the quotient field doubles as the shifting dividend.
    always_comb begin
        count_d   = count_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dbz_d     = dbz_q;
        if (state_q == DIV_IDLE && launch) begin
            dbz_d   = (src0 == '0);
            count_d = '0;
            if (src0 == '0) begin
                quot_d = '1;
                rem_d  = src1;
            end else begin
                divisor_d = src0;
                rem_d     = '0;
                quot_d    = src1;
            end
        end else if (state_q == DIV_RUN) begin
            rem_d   = step_rem;
            quot_d  = step_quot;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dbz_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            dbz_q     <= dbz_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard-driven bench for the multi-cycle divide sequencer
module tb_div_seq;
    import div_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  func;
    logic [15:0] src1;
    logic [15:0] src0;
    logic        flush;
    logic        stall;
    logic        done;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        dbz;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    div_seq #(.DIV_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .func  (func),
        .src1  (src1),
        .src0  (src0),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .quot  (quot),
        .rem   (rem),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a rising edge: this cycle becomes cycle 0 of the operation.
    task automatic issue_div(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        start = 1'b1;
        func  = DIV;
        src1  = a;
        src0  = b;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.z = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.z = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL launch_stall: got %b want 1", stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        src1  = 16'($urandom);
        src0  = 16'($urandom);
    endtask

    // Returns at the negedge of the done cycle after checking latency and results.
    task automatic wait_done(input string name, input int exp_lat);
        exp_t e;
        int   cyc;
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n_checks++;
            if (stall !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_run_stall: cycle %0d got %b want 1", name, cyc, stall);
            end
            cyc++;
            if (cyc < 40) begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (cyc !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_lat);
        end
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty want entry", name);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (quot !== e.q) begin
                n_fail++;
                $display("FAIL %s_quot: got %h want %h", name, quot, e.q);
            end
            n_checks++;
            if (rem !== e.r) begin
                n_fail++;
                $display("FAIL %s_rem: got %h want %h", name, rem, e.r);
            end
            n_checks++;
            if (dbz !== e.z) begin
                n_fail++;
                $display("FAIL %s_dbz: got %b want %b", name, dbz, e.z);
            end
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_stall: got %b want 0", name, stall);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; func = ADD; src1 = '0; src0 = '0; flush = 1'b0;
        #2;
        n_checks++;
        if ({stall, done, dbz, quot, rem} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%b%b %h %h want all zero", stall, done, dbz, quot, rem);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        issue_div(16'd100, 16'd7);
        wait_done("div100_7", 17);
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || quot !== 16'd14 || rem !== 16'd2) begin
            n_fail++;
            $display("FAIL hold_after_done: got done=%b q=%h r=%h want 0 000e 0002", done, quot, rem);
        end
        @(posedge clk); #1;
        issue_div(16'hFFFF, 16'h0001);
        wait_done("ffff_1", 17);
        @(posedge clk); #1;
        issue_div(16'h0003, 16'hFFFF);
        wait_done("3_ffff", 17);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            issue_div(16'($urandom), 16'($urandom_range(1, 65535)));
            wait_done("random", 17);
            @(posedge clk); #1;
        end
        issue_div(16'd0, 16'd9);
        wait_done("zero_dividend", 17);
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        issue_div(16'h1234, 16'h0000);
        wait_done("dbz", 1);
        @(posedge clk); #1;
        issue_div(16'd9, 16'd3);
        wait_done("dbz_clear", 17);
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        exp_t e;
        start = 1'b1; func = DIV; src1 = 16'd77; src0 = 16'd3; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_beats_launch: got stall %b want 0", stall);
        end
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        issue_div(16'd1234, 16'd5);
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        e = sb.pop_front();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_idle: cycle %0d got stall=%b done=%b want 0 0", c, stall, done);
            end
            @(posedge clk); #1;
        end
        issue_div(16'd50, 16'd5);
        wait_done("after_flush", 17);
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        exp_t e;
        issue_div(16'd1000, 16'd3);
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stall, done, dbz, quot, rem} !== 35'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b%b%b %h %h want all zero", stall, done, dbz, quot, rem);
        end
        e = sb.pop_front();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b1; func = ADD; src1 = 16'd5; src0 = 16'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL add_no_stall: cycle %0d got stall=%b done=%b want 0 0", c, stall, done);
            end
            @(posedge clk); #1;
            src1 = 16'($urandom);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        issue_div(16'd200, 16'd10);
        wait_done("b2b_first", 17);
        @(posedge clk); #1;
        issue_div(16'd9, 16'd4);
        wait_done("b2b_second", 17);
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_flush();
        test_async_reset();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
